// File: rtl/uart_ctrl_pkg.sv
// uart_ctrl_pkg: shared state encoding and constants for the UART TX arbiter
package uart_ctrl_pkg;
  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT_DONE, GAP} arb_state_e;
  localparam int BYTE_W = 8;
  localparam int ACK_TIMEOUT_DEF = 4096;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin selector, first set req bit after rr_ptr modulo N
module rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] rr_ptr,
  output logic                 found,
  output logic [$clog2(N)-1:0] idx
);
  localparam int IW = $clog2(N);
  logic [2*N-1:0] dbl;
  logic [N-1:0] rot;
  int sum;
  assign dbl = {req, req};
  // rot[0] is the requester right after rr_ptr, so the lowest set bit wins
  assign rot = N'(dbl >> ((IW+1)'(rr_ptr) + (IW+1)'(1)));
  always_comb begin
    found = |rot;
    sum = 0;
    for (int p = N - 1; p >= 0; p--) if (rot[p]) sum = int'(rr_ptr) + 1 + p;
    if (sum >= N) sum = sum - N;
    idx = IW'(sum);
  end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART TX byte engine between NUM_REQ producers.
// Define UART_ARB_GAP_EN to insert GAP_TICKS idle baud ticks between frames.
module uart_tx_arbiter
  import uart_ctrl_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF,
  parameter int GAP_TICKS   = 2
) (
  input  logic                        system_clock,
  input  logic                        rst,
  input  logic                        clock_enable,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*BYTE_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic                        tx_busy,
  output logic                        center_push,
  output logic [BYTE_W-1:0]           data_in,
  output logic [$clog2(NUM_REQ)-1:0]  grant_id,
  output logic                        arb_busy,
  output logic                        err_timeout
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(ACK_TIMEOUT);
  arb_state_e state;
  logic [IW-1:0] rr_ptr, pick_idx;
  logic found;
  logic [CW-1:0] cnt;
`ifdef UART_ARB_GAP_EN
  localparam int GW = $clog2(GAP_TICKS + 1);
  logic [GW-1:0] gap_cnt;
`else
  logic unused_gap;
  assign unused_gap = clock_enable ^ (GAP_TICKS == 0);
`endif
  rr_pick #(.N(NUM_REQ)) u_pick (
    .req    (req_valid),
    .rr_ptr (rr_ptr),
    .found  (found),
    .idx    (pick_idx)
  );
  assign arb_busy = state != IDLE;
  always_ff @(posedge system_clock) begin
    if (rst) begin
      state       <= IDLE;
      center_push <= 1'b0;
      data_in     <= '0;
      req_ready   <= '0;
      grant_id    <= '0;
      err_timeout <= 1'b0;
      rr_ptr      <= IW'(NUM_REQ - 1);
      cnt         <= '0;
`ifdef UART_ARB_GAP_EN
      gap_cnt     <= '0;
`endif
    end else begin
      req_ready   <= '0;
      err_timeout <= 1'b0;
      case (state)
        IDLE: if (found) begin
          req_ready <= NUM_REQ'(1) << pick_idx;
          data_in   <= req_data[{pick_idx, 3'b000} +: BYTE_W];
          grant_id  <= pick_idx;
          rr_ptr    <= pick_idx;
          cnt       <= '0;
          state     <= LAUNCH;
        end
        // center_push rises one cycle after req_ready and stays up until acked or dropped
        LAUNCH: if (tx_busy) begin
          center_push <= 1'b0;
          state       <= WAIT_DONE;
        end else if (cnt == CW'(ACK_TIMEOUT - 1)) begin
          center_push <= 1'b0;
          err_timeout <= 1'b1;
          state       <= IDLE;
        end else begin
          center_push <= 1'b1;
          cnt         <= cnt + CW'(1);
        end
        WAIT_DONE: if (!tx_busy) begin
`ifdef UART_ARB_GAP_EN
          gap_cnt <= '0;
          state   <= GAP;
`else
          state   <= IDLE;
`endif
        end
`ifdef UART_ARB_GAP_EN
        GAP: if (clock_enable) begin
          if (gap_cnt == GW'(GAP_TICKS - 1)) state <= IDLE;
          else gap_cnt <= gap_cnt + GW'(1);
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed self-checking bench for uart_tx_arbiter (NUM_REQ=4, ACK_TIMEOUT=16)
module tb_uart_tx_arbiter;
  logic        system_clock = 1'b0;
  logic        rst = 1'b1;
  logic        clock_enable = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  req_ready;
  logic        tx_busy = 1'b0;
  logic        center_push;
  logic [7:0]  data_in;
  logic [1:0]  grant_id;
  logic        arb_busy;
  logic        err_timeout;
  int checks = 0;
  int errors = 0;
  uart_tx_arbiter #(.NUM_REQ(4), .ACK_TIMEOUT(16), .GAP_TICKS(2)) dut (
    .system_clock (system_clock),
    .rst          (rst),
    .clock_enable (clock_enable),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .tx_busy      (tx_busy),
    .center_push  (center_push),
    .data_in      (data_in),
    .grant_id     (grant_id),
    .arb_busy     (arb_busy),
    .err_timeout  (err_timeout)
  );
  always #5 system_clock = ~system_clock;
  task automatic tick();
    @(posedge system_clock);
    #1;
  endtask
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic wait_ready();
    int n;
    n = 0;
    while (req_ready === 4'b0 && n < 40) begin
      tick();
      n++;
    end
    check("ready_seen", {31'b0, req_ready !== 4'b0}, 32'd1);
  endtask
  task automatic complete();
    int n;
    n = 0;
    while (center_push !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    check("push_seen", {31'b0, center_push}, 32'd1);
    tx_busy = 1'b1;
    tick();
    tick();
    tx_busy = 1'b0;
    clock_enable = 1'b1;
    n = 0;
    while (arb_busy !== 1'b0 && n < 40) begin
      tick();
      n++;
    end
    clock_enable = 1'b0;
    check("back_idle", {31'b0, arb_busy}, 32'd0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end
  initial begin
    logic bad;
    int pulses;
    tick();
    tick();
    rst = 1'b0;
    check("rst_push", {31'b0, center_push}, 32'd0);
    check("rst_data", {24'b0, data_in}, 32'h00);
    check("rst_ready", {28'b0, req_ready}, 32'd0);
    check("rst_grant", {30'b0, grant_id}, 32'd0);
    check("rst_busy", {31'b0, arb_busy}, 32'd0);
    check("rst_err", {31'b0, err_timeout}, 32'd0);
    req_valid = 4'b0001;
    req_data[7:0] = 8'hA5;
    tick();
    check("single_ready", {28'b0, req_ready}, 32'b0001);
    check("single_grant", {30'b0, grant_id}, 32'd0);
    check("single_busy", {31'b0, arb_busy}, 32'd1);
    check("single_push_lat", {31'b0, center_push}, 32'd0);
    req_valid = 4'b0000;
    tick();
    check("single_push", {31'b0, center_push}, 32'd1);
    check("single_data", {24'b0, data_in}, 32'hA5);
    check("single_ready_once", {28'b0, req_ready}, 32'd0);
    tick();
    check("single_hold1", {31'b0, center_push}, 32'd1);
    tick();
    check("single_hold2", {31'b0, center_push}, 32'd1);
    check("single_data_hold", {24'b0, data_in}, 32'hA5);
    tx_busy = 1'b1;
    req_valid = 4'b0001;
    req_data[7:0] = 8'h5A;
    tick();
    check("single_push_drop", {31'b0, center_push}, 32'd0);
    check("single_no_accept1", {28'b0, req_ready}, 32'd0);
    tick();
    check("single_no_accept2", {28'b0, req_ready}, 32'd0);
    tx_busy = 1'b0;
    tick();
`ifndef UART_ARB_GAP_EN
    check("single_idle", {31'b0, arb_busy}, 32'd0);
`endif
    clock_enable = 1'b1;
    wait_ready();
    clock_enable = 1'b0;
    check("single_b2b_ready", {28'b0, req_ready}, 32'b0001);
    check("single_b2b_data", {24'b0, data_in}, 32'h5A);
    req_valid = 4'b0000;
    complete();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req_valid = 4'b1111;
    req_data = 32'h13121110;
    for (int g = 0; g < 5; g++) begin
      wait_ready();
      check("cont_ready", {28'b0, req_ready}, 32'd1 << (g % 4));
      check("cont_grant", {30'b0, grant_id}, 32'(g % 4));
      check("cont_data", {24'b0, data_in}, 32'h10 + 32'(g % 4));
      if (g == 4) req_valid = 4'b0000;
      complete();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req_valid = 4'b0001;
    req_data[7:0] = 8'h3C;
    tick();
    check("to_ready0", {28'b0, req_ready}, 32'b0001);
    req_valid = 4'b0010;
    req_data[15:8] = 8'h4D;
    for (int k = 1; k < 16; k++) begin
      tick();
      check("to_no_err", {31'b0, err_timeout}, 32'd0);
      check("to_push", {31'b0, center_push}, 32'd1);
    end
    tick();
    check("to_err", {31'b0, err_timeout}, 32'd1);
    check("to_push_drop", {31'b0, center_push}, 32'd0);
    check("to_idle", {31'b0, arb_busy}, 32'd0);
    tick();
    check("to_err_pulse", {31'b0, err_timeout}, 32'd0);
    check("to_next_ready", {28'b0, req_ready}, 32'b0010);
    check("to_next_grant", {30'b0, grant_id}, 32'd1);
    req_valid = 4'b0000;
    complete();
    req_valid = 4'b0001;
    wait_ready();
    check("wd_ready0", {28'b0, req_ready}, 32'b0001);
    req_valid = 4'b0000;
    tick();
    tx_busy = 1'b1;
    tick();
    req_valid = 4'b0100;
    tick();
    req_valid = 4'b0000;
    tick();
    tx_busy = 1'b0;
    clock_enable = 1'b1;
    bad = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (req_ready !== 4'b0 || center_push !== 1'b0) bad = 1'b1;
    end
    clock_enable = 1'b0;
    check("wd_no_tx", {31'b0, bad}, 32'd0);
    check("wd_idle", {31'b0, arb_busy}, 32'd0);
    req_valid = 4'b0100;
    req_data[23:16] = 8'h99;
    wait_ready();
    check("mid_ready2", {28'b0, req_ready}, 32'b0100);
    req_valid = 4'b0000;
    tick();
    check("mid_push", {31'b0, center_push}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_push_clr", {31'b0, center_push}, 32'd0);
    check("mid_busy_clr", {31'b0, arb_busy}, 32'd0);
    check("mid_data_clr", {24'b0, data_in}, 32'h00);
    req_valid = 4'b1111;
    tick();
    check("mid_first_ready", {28'b0, req_ready}, 32'b0001);
    check("mid_first_grant", {30'b0, grant_id}, 32'd0);
    req_valid = 4'b0000;
    complete();
`ifdef UART_ARB_GAP_EN
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req_valid = 4'b0001;
    req_data[7:0] = 8'h77;
    wait_ready();
    tick();
    tx_busy = 1'b1;
    tick();
    tx_busy = 1'b0;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      clock_enable = (i % 3 == 2);
      tick();
      if (clock_enable) pulses++;
      clock_enable = 1'b0;
      if (req_ready !== 4'b0) break;
    end
    check("gap_pulses", 32'(pulses), 32'd2);
    check("gap_ready", {28'b0, req_ready}, 32'b0001);
    req_valid = 4'b0000;
    complete();
`else
    pulses = 0;
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares a single UART TX byte engine between NUM_REQ byte producers, using round-robin arbitration.
- Latches one byte from the winning requester.
- Drives the engine's center_push/data_in pulse-and-hold handshake until the engine reports tx_busy, then waits for the frame to finish before granting again.
- Sits between application byte sources (status reporters, debug dumpers) and the TX FSM. The TX FSM runs on the clock_enable baud tick; this block runs on every system_clock edge.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ACK_TIMEOUT, 4096, system_clock cycles allowed in LAUNCH for tx_busy to rise before the byte is dropped.
- GAP_TICKS, 2, idle baud ticks inserted between frames (only with UART_ARB_GAP_EN).

Ports:
- system_clock  in  1  single clock for all logic.
- rst  in  1  synchronous, active-high reset.
- clock_enable  in  1  baud tick shared with the TX FSM; only used for gap counting.
- req_valid  in  NUM_REQ  per-requester byte available.
- req_data  in  NUM_REQ*8  requester i byte at [8i+7:8i].
- req_ready  out  NUM_REQ  one-cycle accept pulse, at most one bit set.
- tx_busy  in  1  busy flag from the TX FSM.
- center_push  out  1  start request to the TX FSM.
- data_in  out  8  byte to the TX FSM.
- grant_id  out  $clog2(NUM_REQ)  index of the last accepted requester.
- arb_busy  out  1  high in any state other than IDLE.
- err_timeout  out  1  one-cycle pulse when a byte is dropped by the timeout.

Behaviour:
- Reset (rst=1 at posedge) applies to all outputs and pointers:
  - state=IDLE.
  - center_push=0, data_in=8'h00, req_ready=0, grant_id=0, arb_busy=0, err_timeout=0.
  - rr_ptr=NUM_REQ-1, so requester 0 wins first.
  - Reset mid-frame abandons the byte without retry. The TX FSM resets independently.
- IDLE:
  - If any req_valid is set, pick the first set bit searching from rr_ptr+1 upward, modulo NUM_REQ.
  - In the same cycle, pulse req_ready[i] and latch req_data[i] into data_reg.
  - Set grant_id=i and rr_ptr=i, then go to LAUNCH.
  - Otherwise stay in IDLE.
- LAUNCH:
  - center_push=1 and data_in=data_reg, both held stable.
  - Timeout counter increments each cycle.
  - tx_busy=1 -> WAIT_DONE, center_push=0 from the next cycle.
  - Counter reaches ACK_TIMEOUT-1 with tx_busy=0 -> pulse err_timeout, drop center_push, go to IDLE.
- WAIT_DONE: center_push=0; tx_busy=0 -> IDLE (or GAP when the feature is enabled).
- Requester rules:
  - Hold req_valid and req_data stable until req_ready.
  - Dropping req_valid before acceptance is legal; nothing is sent for that requester.
  - Next byte may be presented in the cycle after req_ready.
- Fairness: a requester that holds valid continuously is served at most once per NUM_REQ grants while others are pending. A lone requester is served back-to-back.
- Latency:
  - req_valid to req_ready: 1 cycle when IDLE.
  - req_ready to center_push: 1 cycle.
- If tx_busy is already 1 on entry to LAUNCH (foreign user), LAUNCH exits immediately. Callers must not share the TX FSM outside this block.
- data_in retains the last byte when idle, and is never changed while center_push=1.

Optional Feature:
- Macro UART_ARB_GAP_EN.
- Defined:
  - WAIT_DONE goes to GAP on tx_busy=0.
  - GAP counts clock_enable pulses; after GAP_TICKS pulses -> IDLE.
  - arb_busy stays high in GAP, and no req_ready is issued during GAP.
- Undefined: no GAP state, GAP_TICKS is ignored, and WAIT_DONE goes straight to IDLE.

Decomposition:
- Package uart_ctrl_pkg holds:
  - typedef enum logic [2:0] arb_state_e {IDLE, LAUNCH, WAIT_DONE, GAP}.
  - localparam BYTE_W=8.
  - Default ACK_TIMEOUT.
- Sub-module rr_pick: combinational round-robin selector.
  - Inputs: req vector and rr_ptr.
  - Outputs: found and idx.
  - Instantiated once.

Test Plan:
- Single requester: req_valid[0]=1, data 8'hA5, TX model raises tx_busy 3 cycles after push. Required: req_ready[0] pulses once, center_push holds until tx_busy=1, data_in=8'hA5, next byte is accepted only after tx_busy falls.
- Contention: all four valid with 8'h10..8'h13 held continuously. Required: grant order 0,1,2,3,0 and data_in sequence 10,11,12,13,10.
- Timeout: ACK_TIMEOUT=16, tx_busy tied 0. Required: err_timeout pulses exactly 16 cycles after LAUNCH entry, center_push returns to 0, state returns to IDLE, req 1 is then accepted.
- Withdrawn request: req_valid[2] pulses for 1 cycle while in WAIT_DONE. Required: no req_ready[2] and no transmission.
- Reset mid-frame: rst=1 during LAUNCH. Required: next cycle center_push=0, arb_busy=0, rr_ptr restored so requester 0 wins first.
- UART_ARB_GAP_EN defined, GAP_TICKS=2: back-to-back bytes. Required: exactly 2 clock_enable pulses between tx_busy falling and the next req_ready.
